// File: rtl/dmem_responder.sv
// Data-memory responder: a valid/ready load/store target modelling a RAM with WAIT_CYCLES wait states.
// Optional macro DMEM_BYTE_WRITE_EN makes stores honour req_be; without it every store writes the full word.
module dmem_responder #(
   parameter int ADDR_W      = 5,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int         DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic              accept, acc_en, acc_we, acc_err, mem_we;
   logic [31:0]       acc_addr, acc_wdata;
   logic [3:0]        acc_be;
   logic [ADDR_W-1:0] acc_idx;

   logic [31:0] mem [DEPTH];

   assign req_ready = reset && (state_q == IDLE);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // With no wait states the access happens on the acceptance edge, so it uses the live request.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_en    = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  acc_en    = 1'b1;
                  acc_we    = req_we;
                  acc_addr  = req_addr;
                  acc_wdata = req_wdata;
                  acc_be    = req_be;
                  state_d   = RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               acc_en  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
   assign acc_idx = acc_addr[ADDR_W+1:2];
   assign mem_we  = acc_en && acc_we && !acc_err;

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (acc_en) begin
         err_d   = acc_err;
         rdata_d = (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
      end
   end

   // The array has no reset; mem_we is already low whenever reset is asserted.
`ifdef DMEM_BYTE_WRITE_EN
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end
`else
   logic unused_be;
   assign unused_be = ^acc_be;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked every cycle against a timeline model.
module tb_dmem_responder;
   localparam int W0 = 2;
   localparam int W1 = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
   logic [1:0][3:0]  req_be;

   dmem_responder #(.ADDR_W(5), .WAIT_CYCLES(W0)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_responder #(.ADDR_W(5), .WAIT_CYCLES(W1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s lane%0d: got %h expected %h", nm, ln, act, exp);
      end
   endtask

   function automatic int wc(input int ln);
      return (ln == 0) ? W0 : W1;
   endfunction

   // Model: one outstanding request per lane; its memory effect lands W edges after acceptance.
   bit          m_busy [2];
   int          m_due  [2];
   bit          m_we   [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wd   [2];
   logic [3:0]  m_be   [2];
   logic [31:0] m_rd   [2];
   bit          m_er   [2];
   logic [31:0] m_mem  [2][32];

   task automatic m_access(input int ln);
      bit          e;
      int          idx;
      logic [31:0] mask;
      e = (m_addr[ln] % 4 != 0) || (m_addr[ln] >= 32'd128);
      m_er[ln] = e;
      m_rd[ln] = 32'd0;
      if (!e) begin
         idx = int'(m_addr[ln] / 4);
         if (m_we[ln]) begin
`ifdef DMEM_BYTE_WRITE_EN
            mask = {{8{m_be[ln][3]}}, {8{m_be[ln][2]}}, {8{m_be[ln][1]}}, {8{m_be[ln][0]}}};
`else
            mask = 32'hFFFF_FFFF;
`endif
            m_mem[ln][idx] = (m_mem[ln][idx] & ~mask) | (m_wd[ln] & mask);
         end else begin
            m_rd[ln] = m_mem[ln][idx];
         end
      end
   endtask

   initial begin
      for (int ln = 0; ln < 2; ln++) m_busy[ln] = 1'b0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            for (int ln = 0; ln < 2; ln++) m_busy[ln] = 1'b0;
         end else begin
            cyc++;
            for (int ln = 0; ln < 2; ln++) begin
               if (m_busy[ln] && m_due[ln] == 0) begin
                  if (rsp_ready[ln]) m_busy[ln] = 1'b0;
               end else if (m_busy[ln]) begin
                  m_due[ln]--;
                  if (m_due[ln] == 0) m_access(ln);
               end else if (req_valid[ln]) begin
                  m_we[ln]   = req_we[ln];
                  m_addr[ln] = req_addr[ln];
                  m_wd[ln]   = req_wdata[ln];
                  m_be[ln]   = req_be[ln];
                  m_busy[ln] = 1'b1;
                  m_due[ln]  = wc(ln);
                  if (m_due[ln] == 0) m_access(ln);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int ln = 0; ln < 2; ln++) begin
            check("req_ready", ln, 32'(req_ready[ln]), 32'(reset && !m_busy[ln]));
            check("rsp_valid", ln, 32'(rsp_valid[ln]), 32'(reset && m_busy[ln] && m_due[ln] == 0));
            if (reset && m_busy[ln] && m_due[ln] == 0) begin
               check("rsp_rdata", ln, rsp_rdata[ln], m_rd[ln]);
               check("rsp_err", ln, 32'(rsp_err[ln]), 32'(m_er[ln]));
            end
         end
      end
   end

   task automatic txn(input int ln, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int delay,
                      output logic [31:0] rd, output bit er, output int lat, output int acc);
      int budget;
      @(negedge clk);
      req_we[ln]    = we;
      req_addr[ln]  = addr;
      req_wdata[ln] = wdata;
      req_be[ln]    = be;
      req_valid[ln] = 1'b1;
      rsp_ready[ln] = (delay == 0);
      budget = 0;
      while (!req_ready[ln] && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 50) begin
         n_chk++;
         n_err++;
         $display("FAIL accept_timeout lane%0d: req_ready never rose", ln);
      end
      acc = cyc + 1;
      @(negedge clk);
      req_valid[ln] = 1'b0;
      req_we[ln]    = 1'($urandom_range(0, 1));
      req_addr[ln]  = $urandom;
      req_wdata[ln] = $urandom;
      lat = 1;
      while (!rsp_valid[ln] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 40) begin
         n_chk++;
         n_err++;
         $display("FAIL rsp_timeout lane%0d: rsp_valid never rose", ln);
      end
      rd = rsp_rdata[ln];
      er = rsp_err[ln];
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         check("bp_valid_held", ln, 32'(rsp_valid[ln]), 32'd1);
         check("bp_ready_low", ln, 32'(req_ready[ln]), 32'd0);
         req_valid[ln] = 1'b1;
      end
      req_valid[ln] = 1'b0;
      rsp_ready[ln] = 1'b1;
      $display("txn lane%0d we=%0d addr=%h wdata=%h be=%b delay=%0d -> rdata=%h err=%0d lat=%0d",
               ln, we, addr, wdata, be, delay, rd, er, lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, addr;
      bit          er;
      int          lat, ac, ac_prev, ln, r;
      logic [31:0] exp_bw;

      reset     = 1'b0;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", 0, 32'(req_ready[0]), 32'd0);
      check("reset_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
      check("reset_rsp_rdata", 0, rsp_rdata[0], 32'd0);
      check("reset_rsp_err", 0, 32'(rsp_err[0]), 32'd0);
      @(posedge clk);
      #2 reset = 1'b1;

      for (int l = 0; l < 2; l++)
         for (int i = 0; i < 32; i++)
            txn(l, 1'b1, 32'(i * 4), 32'd0, 4'hF, 0, rd, er, lat, ac);

      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, ac);
      check("store_latency", 0, 32'(lat), 32'd3);
      check("store_err", 0, 32'(er), 32'd0);
      check("store_rdata", 0, rd, 32'd0);
      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, rd, er, lat, ac);
      check("load_rdata", 0, rd, 32'hDEADBEEF);
      check("load_latency", 0, 32'(lat), 32'd3);
      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 5, rd, er, lat, ac);
      check("bp_load_rdata", 0, rd, 32'hDEADBEEF);

      txn(0, 1'b1, 32'h13, 32'h0BADF00D, 4'hF, 0, rd, er, lat, ac);
      check("misaligned_err", 0, 32'(er), 32'd1);
      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, rd, er, lat, ac);
      check("after_err_rdata", 0, rd, 32'hDEADBEEF);
      txn(0, 1'b0, 32'h80, 32'd0, 4'hF, 0, rd, er, lat, ac);
      check("range_err", 0, 32'(er), 32'd1);
      check("range_rdata", 0, rd, 32'd0);

      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, rd, er, lat, ac_prev);
      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, rd, er, lat, ac);
      check("spacing_w2", 0, 32'(ac - ac_prev), 32'd4);

      ac_prev = 0;
      for (int k = 0; k < 4; k++) begin
         txn(1, 1'b0, 32'(k * 4), 32'd0, 4'hF, 0, rd, er, lat, ac);
         check("latency_w0", 1, 32'(lat), 32'd1);
         if (k > 0) check("spacing_w0", 1, 32'(ac - ac_prev), 32'd2);
         ac_prev = ac;
      end

      @(negedge clk);
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'h04;
      req_wdata[0] = 32'h12345678;
      req_be[0]    = 4'hF;
      req_valid[0] = 1'b1;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
      check("midrst_req_ready", 0, 32'(req_ready[0]), 32'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      txn(0, 1'b0, 32'h04, 32'd0, 4'hF, 0, rd, er, lat, ac);
      check("midrst_no_write", 0, rd, 32'd0);

      txn(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 0, rd, er, lat, ac);
      txn(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 0, rd, er, lat, ac);
      txn(0, 1'b0, 32'h08, 32'd0, 4'hF, 0, rd, er, lat, ac);
`ifdef DMEM_BYTE_WRITE_EN
      exp_bw = 32'hAA22CC44;
`else
      exp_bw = 32'h11223344;
`endif
      check("byte_write", 0, rd, exp_bw);

      for (int k = 0; k < 80; k++) begin
         ln = int'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         if (r == 0)      addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
         else if (r == 1) addr = $urandom | 32'h80;
         else             addr = 32'($urandom_range(0, 31) * 4);
         txn(ln, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0, rd, er, lat, ac);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target side of the CPU's load/store port.
- Accepts one word-wide load/store request at a time over a valid/ready handshake and models a RAM with a configurable number of wait states.
- Returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the CPU's zero-latency internal RAM array so the pipeline can be exercised against a memory with realistic latency.

Parameters:
ADDR_W, 5, word-index width; DEPTH = 2**ADDR_W words (default 32 words = 128 bytes)
WAIT_CYCLES, 2, extra cycles between request acceptance and memory access; 0 legal, max 15

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables for stores (bit i = byte i, little-endian)
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  32  load data; 0 for stores and errors
rsp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, req_ready=0 while asserted, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is not cleared.
  - Request and response registers cleared.
  - Reset mid-transaction discards the transaction; no partial write.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready, capture we/addr/wdata/be.
    - WAIT_CYCLES=0: go to RESP.
    - Otherwise: go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT: req_ready=0. Decrement counter each cycle. At counter=0, perform the access and go to RESP.
  - RESP: rsp_valid=1, rsp_rdata/rsp_err stable. On rsp_valid&rsp_ready go to IDLE. rsp_valid is held indefinitely until taken.
- Access point:
  - The memory access happens on the edge entering RESP.
  - Loads sample mem[req_addr[ADDR_W+1:2]] into rsp_rdata.
  - Stores write the word, with byte enables per the optional feature.
- Latency and throughput:
  - rsp_valid is first high WAIT_CYCLES+1 cycles after the acceptance edge.
  - req_ready returns high in the cycle after the response handshake.
  - Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
  - No request is accepted in the same cycle a response is consumed.
- Error checks (evaluated on the captured request):
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr[31:ADDR_W+2]!=0.
  - Either condition: rsp_err=1, no write, rsp_rdata=0. The handshake and latency are unchanged.
- Stores: rsp_rdata=0, rsp_err=0 unless an error condition applies.
- Ordering: a single outstanding request, so a load after a store to the same address returns the stored data.
- Inputs are sampled only at the acceptance edge; changes to req_* afterwards are ignored.
- req_valid in WAIT/RESP is ignored and is not counted as accepted.

Optional Feature:
- Macro: DMEM_BYTE_WRITE_EN.
- Defined: stores update only the bytes whose req_be bit is 1; req_be=4'b0000 is a legal no-op store that still returns a response.
- Undefined: req_be is ignored and every non-error store writes the full 32-bit word.

Test Plan:
- Reset, basic store/load, WAIT_CYCLES=2:
  - Release reset.
  - Store 0xDEADBEEF to addr 0x10; rsp_valid appears 3 cycles after acceptance with rsp_err=0.
  - Load addr 0x10; rsp_rdata=0xDEADBEEF.
- Backpressure:
  - Load with rsp_ready=0 for 5 cycles; rsp_valid stays 1 and rsp_rdata stays constant.
  - req_ready stays 0 throughout; a new req_valid is ignored until 1 cycle after rsp_ready=1.
- Errors:
  - Store to 0x13: rsp_err=1, and a later load of 0x10 is unchanged.
  - Load from 0x80 with ADDR_W=5: rsp_err=1, rsp_rdata=0.
- Zero wait, WAIT_CYCLES=0:
  - Back-to-back loads with rsp_ready tied 1; each response arrives 1 cycle after acceptance.
  - Acceptances occur every 2 cycles.
- Reset mid-operation:
  - Assert reset during WAIT of a store of 0x12345678 to 0x04 (previously 0x0); rsp_valid drops immediately.
  - After release, load of 0x04 returns 0x0.
- Byte write, with DMEM_BYTE_WRITE_EN:
  - Word 0x08 = 0xAABBCCDD; store 0x11223344 with be=4'b0101.
  - Load returns 0xAA22CC44.
  - Without the macro, the same load returns 0x11223344.
